// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: time-division framer sharing one UART byte stream among CIC channels
module uart_frame_scheduler #(
    parameter int p_channels = 4,
    parameter int p_width = 16,
    parameter int p_bytes = 1,
    parameter logic [7:0] p_sync = 8'hA5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_strobe,
    input  logic [p_channels*p_width-1:0] i_data,
    input  logic                          i_ready,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    output logic [2:0]                    o_chan,
    output logic                          o_busy,
    output logic                          o_overrun,
    output logic [7:0]                    o_dropCount
);
    typedef enum logic [1:0] {IDLE, SYNC, HI, LO} state_t;
    localparam logic [2:0] last_ch = 3'(p_channels - 1);
    state_t state, state_n;
    logic [2:0] ch, ch_n;
    logic [127:0] snap;
    logic xfer, last, accept;
    // next state, channel advance and byte presentation
    always_comb begin
        state_n = state;
        ch_n = ch;
        o_valid = state != IDLE;
        o_busy = state != IDLE;
        o_chan = (state == HI || state == LO) ? ch : 3'd0;
        o_data = state == SYNC ? p_sync :
                 state == HI   ? snap[{ch, 4'b1000} +: 8] :
                 state == LO   ? snap[{ch, 4'b0000} +: 8] : 8'h00;
        xfer = o_valid && i_ready;
        last = xfer && ch == last_ch && (state == LO || (state == HI && p_bytes == 1));
        accept = i_strobe && (state == IDLE || last);
        case (state)
            IDLE: state_n = accept ? SYNC : IDLE;
            SYNC: begin
                state_n = xfer ? HI : SYNC;
                ch_n = xfer ? 3'd0 : ch;
            end
            HI: if (xfer) begin
                state_n = p_bytes == 2 ? LO : ch == last_ch ? (accept ? SYNC : IDLE) : HI;
                ch_n = (p_bytes != 2 && ch != last_ch) ? ch + 3'd1 : ch;
            end
            LO: if (xfer) begin
                state_n = ch == last_ch ? (accept ? SYNC : IDLE) : HI;
                ch_n = ch == last_ch ? ch : ch + 3'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    // state, snapshot capture and dropped-strobe bookkeeping
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            ch <= 3'd0;
            snap <= '0;
            o_overrun <= 1'b0;
            o_dropCount <= 8'h00;
        end else begin
            state <= state_n;
            ch <= ch_n;
            if (accept) snap <= 128'(i_data);
            o_overrun <= i_strobe && !accept;
            if (i_strobe && !accept && o_dropCount != 8'hFF) o_dropCount <= o_dropCount + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler: frame-position model checks of 1-byte and 2-byte scheduler variants
module tb_uart_frame_scheduler;
    localparam int NC = 4;
    localparam logic [63:0] D = {16'h4455, 16'h3344, 16'h2233, 16'h1122};
    logic clk = 0, rst_n = 0, strobe = 0, ready = 0;
    logic [NC*16-1:0] data = '0;
    logic [7:0] d_data[2], d_drop[2];
    logic [2:0] d_chan[2];
    logic d_valid[2], d_busy[2], d_over[2];
    int pos[2];
    logic [15:0] m_snap[2][NC];
    logic m_over[2];
    int m_drop[2];
    int n_cmp = 0, n_fail = 0;
    logic [7:0] e0[5] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0] c0[5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [7:0] e1[9] = '{8'hA5, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h55};
    logic [2:0] c1[9] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};

    uart_frame_scheduler #(.p_channels(NC), .p_width(16), .p_bytes(1), .p_sync(8'hA5)) u0 (
        .i_clk(clk), .i_rst(rst_n), .i_strobe(strobe), .i_data(data), .i_ready(ready),
        .o_data(d_data[0]), .o_valid(d_valid[0]), .o_chan(d_chan[0]), .o_busy(d_busy[0]),
        .o_overrun(d_over[0]), .o_dropCount(d_drop[0]));
    uart_frame_scheduler #(.p_channels(NC), .p_width(16), .p_bytes(2), .p_sync(8'hA5)) u1 (
        .i_clk(clk), .i_rst(rst_n), .i_strobe(strobe), .i_data(data), .i_ready(ready),
        .o_data(d_data[1]), .o_valid(d_valid[1]), .o_chan(d_chan[1]), .o_busy(d_busy[1]),
        .o_overrun(d_over[1]), .o_dropCount(d_drop[1]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Frame position p: 0 idle, 1 sync, 2.. sample bytes in channel-major, MSB-first order
    function automatic logic [7:0] exp_data(input int i);
        int k;
        if (pos[i] == 0) return 8'h00;
        if (pos[i] == 1) return 8'hA5;
        k = pos[i] - 2;
        return (k % (i + 1) == 0) ? m_snap[i][k / (i + 1)][15:8] : m_snap[i][k / (i + 1)][7:0];
    endfunction

    function automatic logic [2:0] exp_chan(input int i);
        return pos[i] <= 1 ? 3'd0 : 3'((pos[i] - 2) / (i + 1));
    endfunction

    task automatic model_step(input int i);
        int len;
        bit xfer, idle0;
        len = 1 + NC * (i + 1);
        idle0 = pos[i] == 0;
        xfer = !idle0 && ready;
        if (xfer) pos[i] = pos[i] == len ? 0 : pos[i] + 1;
        m_over[i] = 0;
        if (strobe) begin
            if (idle0 || (xfer && pos[i] == 0)) begin
                for (int c = 0; c < NC; c++) m_snap[i][c] = data[c*16 +: 16];
                pos[i] = 1;
            end else begin
                m_over[i] = 1;
                if (m_drop[i] < 255) m_drop[i]++;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pos[i] = 0;
                m_over[i] = 0;
                m_drop[i] = 0;
                for (int c = 0; c < NC; c++) m_snap[i][c] = 16'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("valid", i, 32'(d_valid[i]), 32'(pos[i] != 0));
            chk("busy", i, 32'(d_busy[i]), 32'(pos[i] != 0));
            chk("data", i, 32'(d_data[i]), 32'(exp_data(i)));
            chk("chan", i, 32'(d_chan[i]), 32'(exp_chan(i)));
            chk("overrun", i, 32'(d_over[i]), 32'(m_over[i]));
            chk("dropcount", i, 32'(d_drop[i]), 32'(m_drop[i]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 32'(d_valid[i]), 32'd0);
            chk("rst_data", i, 32'(d_data[i]), 32'd0);
            chk("rst_drop", i, 32'(d_drop[i]), 32'd0);
        end
        rst_n = 1;
        cyc();
        ready = 1;
        data = D;
        strobe = 1;
        cyc();
        strobe = 0;
        for (int j = 0; j < 9; j++) begin
            if (j < 5) begin
                chk("basic_data", 0, 32'(d_data[0]), 32'(e0[j]));
                chk("basic_chan", 0, 32'(d_chan[0]), 32'(c0[j]));
            end
            if (j == 5) chk("basic_busy_fall", 0, 32'(d_busy[0]), 32'd0);
            chk("two_byte_data", 1, 32'(d_data[1]), 32'(e1[j]));
            chk("two_byte_chan", 1, 32'(d_chan[1]), 32'(c1[j]));
            cyc();
        end
        strobe = 1;
        cyc();
        strobe = 0;
        cyc();
        ready = 0;
        data = {$urandom, $urandom};
        repeat (3) begin
            strobe = 1;
            cyc();
            strobe = 0;
            chk("overrun_pulse", 0, 32'(d_over[0]), 32'd1);
            cyc();
            chk("overrun_single", 0, 32'(d_over[0]), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            chk("drop3", i, 32'(d_drop[i]), 32'd3);
            chk("first_snapshot", i, 32'(d_data[i]), 32'h11);
        end
        strobe = 1;
        repeat (297) cyc();
        strobe = 0;
        cyc();
        for (int i = 0; i < 2; i++) chk("drop_saturate", i, 32'(d_drop[i]), 32'hFF);
        ready = 1;
        repeat (12) cyc();
        for (int i = 0; i < 2; i++) chk("drained", i, 32'(d_busy[i]), 32'd0);
        data = D;
        strobe = 1;
        cyc();
        strobe = 0;
        repeat (4) cyc();
        chk("b2b_last", 0, 32'(d_data[0]), 32'h44);
        strobe = 1;
        data = {4{16'hAAAA}};
        cyc();
        strobe = 0;
        chk("b2b_valid", 0, 32'(d_valid[0]), 32'd1);
        chk("b2b_sync", 0, 32'(d_data[0]), 32'hA5);
        chk("b2b_no_overrun", 0, 32'(d_over[0]), 32'd0);
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("b2b_data", 0, 32'(d_data[0]), 32'hAA);
            chk("b2b_chan", 0, 32'(d_chan[0]), 32'(j));
        end
        repeat (10) cyc();
        data = D;
        strobe = 1;
        cyc();
        strobe = 0;
        repeat (3) cyc();
        chk("pre_reset_data", 0, 32'(d_data[0]), 32'h33);
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_valid", i, 32'(d_valid[i]), 32'd0);
            chk("async_busy", i, 32'(d_busy[i]), 32'd0);
            chk("async_drop", i, 32'(d_drop[i]), 32'd0);
        end
        cyc();
        rst_n = 1;
        cyc();
        data = {$urandom, $urandom};
        strobe = 1;
        cyc();
        strobe = 0;
        for (int i = 0; i < 2; i++) chk("restart_sync", i, 32'(d_data[i]), 32'hA5);
        repeat (3000) begin
            strobe = $urandom_range(0, 9) == 0;
            ready = $urandom_range(0, 9) < 7;
            data = {$urandom, $urandom};
            cyc();
        end
        strobe = 0;
        ready = 1;
        repeat (20) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
